// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester ports, CPU stall and SRAM bus of the two-port memory arbiter
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              req0, wen0, ack0, stall0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic              req1, wen1, ack1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen, mem_ren;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport master (
        output req0, wen0, addr0, wdata0, req1, wen1, addr1, wdata1, mem_rdata,
        input  ack0, rdata0, ack1, rdata1, stall0, mem_addr, mem_wen, mem_ren, mem_wdata
    );
    modport slave (
        input  req0, wen0, addr0, wdata0, req1, wen1, addr1, wdata1, mem_rdata,
        output ack0, rdata0, ack1, rdata1, stall0, mem_addr, mem_wen, mem_ren, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port SRAM between the CPU and a host port
module mem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state;
    logic              last_grant, win, lat_wen, ack0, ack1;
    logic              elig0, elig1, pick1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, rdata0, rdata1;
    logic              mem_wen, mem_ren;
    // a requester whose ack is high this cycle is finishing, not asking again
    assign elig0 = bus.req0 & ~ack0;
    assign elig1 = bus.req1 & ~ack1;
    assign pick1 = elig1 & (~elig0 | ~last_grant);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win        <= 1'b0;
            lat_wen    <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            case (state)
                IDLE: if (elig0 | elig1) begin
                    state      <= ACCESS;
                    win        <= pick1;
                    last_grant <= pick1;
                    lat_wen    <= pick1 ? bus.wen1 : bus.wen0;
                    // SRAM bus registers double as the latched operands for the ACCESS cycle
                    mem_addr   <= pick1 ? bus.addr1 : bus.addr0;
                    mem_wdata  <= pick1 ? bus.wdata1 : bus.wdata0;
                    mem_wen    <= pick1 ? bus.wen1 : bus.wen0;
                    mem_ren    <= ~(pick1 ? bus.wen1 : bus.wen0);
                end
                ACCESS: begin
                    state <= lat_wen ? IDLE : RESP;
                    ack0  <= lat_wen & ~win;
                    ack1  <= lat_wen & win;
                end
                RESP: begin
                    state  <= IDLE;
                    ack0   <= ~win;
                    ack1   <= win;
                    rdata0 <= win ? rdata0 : bus.mem_rdata;
                    rdata1 <= win ? bus.mem_rdata : rdata1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.ack0      = ack0;
    assign bus.ack1      = ack1;
    assign bus.rdata0    = rdata0;
    assign bus.rdata1    = rdata1;
    assign bus.stall0    = bus.req0 & ~ack0;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_wen   = mem_wen;
    assign bus.mem_ren   = mem_ren;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, reset and data path against an SRAM model
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] sram [1024];
    bit [1023:0] written;
    mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(10)) bus ();
    mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    // unwritten words read back as a recognisable address-tagged pattern
    always @(posedge clk) begin
        if (bus.mem_wen) begin
            sram[bus.mem_addr] <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_ren)
            bus.mem_rdata <= written[bus.mem_addr] ? sram[bus.mem_addr] : (32'hC0DE0000 | 32'(bus.mem_addr));
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        int n;
        logic both;
        {bus.req0, bus.wen0, bus.addr0, bus.wdata0} = '0;
        {bus.req1, bus.wen1, bus.addr1, bus.wdata1} = '0;
        tick(2);
        rst = 1'b0;
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_mem_wen", bus.mem_wen, 0);
        chk("rst_mem_ren", bus.mem_ren, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        // single write by requester 1
        bus.req1 = 1; bus.wen1 = 1; bus.addr1 = 5; bus.wdata1 = 32'hA5A5A5A5;
        tick(1);
        chk("wr_mem_wen", bus.mem_wen, 1);
        chk("wr_mem_ren", bus.mem_ren, 0);
        chk("wr_mem_addr", bus.mem_addr, 5);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        chk("wr_ack1_early", bus.ack1, 0);
        tick(1);
        chk("wr_ack1", bus.ack1, 1);
        chk("wr_no_ack0", bus.ack0, 0);
        chk("wr_mem_idle", bus.mem_wen, 0);
        bus.req1 = 0;
        tick(1);
        chk("wr_ack1_pulse", bus.ack1, 0);
        chk("wr_rdata1_kept", bus.rdata1, 0);
        // single read by requester 0
        bus.req0 = 1; bus.wen0 = 0; bus.addr0 = 5;
        #1;
        chk("rd_stall_T", bus.stall0, 1);
        tick(1);
        chk("rd_mem_ren", bus.mem_ren, 1);
        chk("rd_mem_addr", bus.mem_addr, 5);
        chk("rd_stall_T1", bus.stall0, 1);
        tick(1);
        chk("rd_stall_T2", bus.stall0, 1);
        chk("rd_ack0_early", bus.ack0, 0);
        tick(1);
        chk("rd_ack0", bus.ack0, 1);
        chk("rd_rdata0", bus.rdata0, 32'hA5A5A5A5);
        chk("rd_stall_T3", bus.stall0, 0);
        bus.req0 = 0;
        // tie after reset: requester 0 first
        rst = 1;
        tick(1);
        rst = 0;
        chk("tie_rst_rdata0", bus.rdata0, 0);
        bus.req0 = 1; bus.wen0 = 0; bus.addr0 = 5;
        bus.req1 = 1; bus.wen1 = 0; bus.addr1 = 6;
        tick(3);
        chk("tie_ack0", bus.ack0, 1);
        chk("tie_no_ack1", bus.ack1, 0);
        chk("tie_rdata0", bus.rdata0, 32'hA5A5A5A5);
        bus.req0 = 0;
        tick(1);
        chk("tie_mem_ren1", bus.mem_ren, 1);
        chk("tie_mem_addr1", bus.mem_addr, 6);
        tick(2);
        chk("tie_ack1", bus.ack1, 1);
        chk("tie_no_ack0", bus.ack0, 0);
        chk("tie_rdata1", bus.rdata1, 32'hC0DE0006);
        bus.req1 = 0;
        tick(1);
        // continuous contention: grants must alternate 0,1,0,1...
        bus.req0 = 1; bus.wen0 = 1; bus.addr0 = 10; bus.wdata0 = 32'h11;
        bus.req1 = 1; bus.wen1 = 1; bus.addr1 = 11; bus.wdata1 = 32'h22;
        n = 0;
        both = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            tick(1);
            both = both | (bus.ack0 & bus.ack1);
            if (bus.ack0 | bus.ack1) begin
                chk($sformatf("rr_grant%0d", n), 32'(bus.ack1), 32'(n % 2));
                n++;
                if (n == 8) begin
                    bus.req0 = 0;
                    bus.req1 = 0;
                end
            end
        end
        chk("rr_count", n, 8);
        chk("rr_no_double_ack", 32'(both), 0);
        tick(3);
        chk("rr_drained", bus.mem_wen, 0);
        // reset during RESP aborts the read, held request is served afterwards
        bus.req0 = 1; bus.wen0 = 0; bus.addr0 = 5;
        tick(2);
        rst = 1;
        tick(1);
        chk("abort_ack0", bus.ack0, 0);
        chk("abort_rdata0", bus.rdata0, 0);
        chk("abort_mem_ren", bus.mem_ren, 0);
        rst = 0;
        tick(1);
        chk("retry_mem_ren", bus.mem_ren, 1);
        tick(1);
        chk("retry_no_ack0", bus.ack0, 0);
        tick(1);
        chk("retry_ack0", bus.ack0, 1);
        chk("retry_rdata0", bus.rdata0, 32'hA5A5A5A5);
        bus.req0 = 0;
        // write by host then read of the same word by CPU
        bus.req1 = 1; bus.wen1 = 1; bus.addr1 = 7; bus.wdata1 = 32'h1234;
        tick(2);
        chk("wr7_ack1", bus.ack1, 1);
        bus.req1 = 0;
        bus.req0 = 1; bus.wen0 = 0; bus.addr0 = 7;
        tick(3);
        chk("rd7_ack0", bus.ack0, 1);
        chk("rd7_rdata0", bus.rdata0, 32'h1234);
        chk("rd7_rdata1_kept", bus.rdata1, 0);
        bus.req0 = 0;
        tick(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter ADDR_W, default 10, SRAM word-address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  CPU MEM-stage request (requester 0).
REQ-006 wen0  input  1  requester 0: 1 = write, 0 = read.
REQ-007 addr0  input  ADDR_W  requester 0 address.
REQ-008 wdata0  input  DATA_W  requester 0 write data.
REQ-009 ack0  output  1  requester 0 completion pulse.
REQ-010 rdata0  output  DATA_W  requester 0 read data.
REQ-011 req1, wen1, addr1, wdata1, ack1, rdata1  same as REQ-005..REQ-010 for requester 1 (external host port).
REQ-012 stall0  output  1  high while req0=1 and ack0=0; freezes CPU pipeline enable.
REQ-013 mem_addr  output  ADDR_W  SRAM address.
REQ-014 mem_wen  output  1  SRAM write enable.
REQ-015 mem_ren  output  1  SRAM read enable.
REQ-016 mem_wdata  output  DATA_W  SRAM write data.
REQ-017 mem_rdata  input  DATA_W  SRAM read data, valid one cycle after mem_ren cycle.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-019 IDLE: eligible requester = reqN=1 and ackN=0 this cycle; none eligible -> stay IDLE.
REQ-020 IDLE, one eligible: grant it; latch its wen/addr/wdata and winner index; next ACCESS.
REQ-021 IDLE, both eligible: grant requester not equal to last_grant (round-robin); last_grant updated on every grant.
REQ-022 ACCESS (exactly one cycle): mem_addr/mem_wdata = latched values, mem_wen = latched wen, mem_ren = ~latched wen.
REQ-023 Outside ACCESS: mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0.
REQ-024 ACCESS write -> IDLE; ack of winner pulses high for one cycle in that following IDLE cycle.
REQ-025 ACCESS read -> RESP; in RESP capture mem_rdata into winner's rdata register; -> IDLE; ack pulses in the following IDLE cycle with rdata valid.
REQ-026 Latency from req sampled in IDLE (cycle T): write ack at T+2, read ack at T+3.
REQ-027 rdataN holds until next read completion for requester N; writes never change rdataN.
REQ-028 Requester holds req and operands until ack; address/data changes after grant are ignored.
REQ-029 ackN high excludes requester N from arbitration that cycle (no double grant of one held request).
REQ-030 Fairness: a pending requester is granted after at most one transaction of the other.
REQ-031 At most one ack high per cycle; ack0 and ack1 never simultaneous.
REQ-032 stall0 combinational: req0 & ~ack0.

Reset
REQ-033 rst=1 at an edge: state IDLE, last_grant=1 (requester 0 wins first tie), ack0=ack1=0, rdata0=rdata1=0, latched operands 0.
REQ-034 Reset during ACCESS/RESP aborts transaction: no ack issued; a write driven in that ACCESS cycle may complete in SRAM.
REQ-035 Requests held through reset are re-arbitrated from IDLE after rst deasserts.

Verification
REQ-036 Single write: req1=1, wen1=1, addr1=5, wdata1=0xA5A5A5A5 at T -> mem_wen=1, mem_addr=5 at T+1; ack1 at T+2; no ack0.
REQ-037 Single read: SRAM[5]=0xA5A5A5A5, req0=1, wen0=0, addr0=5 at T -> mem_ren at T+1; ack0=1, rdata0=0xA5A5A5A5 at T+3; stall0=1 T..T+2, 0 at T+3.
REQ-038 Tie after reset: req0, req1 both reads at T -> requester 0 served first (ack0 T+3), requester 1 granted T+3, ack1 T+6.
REQ-039 Continuous contention: both requesters re-request immediately after each ack for 8 transactions -> grants alternate 0,1,0,1...; no requester granted twice consecutively.
REQ-040 Reset mid-read: rst=1 during RESP -> no ack, rdata0=0, state IDLE; held req0 served normally after rst=0.
REQ-041 Write-then-read same address by different requesters: req1 write 0x1234 to addr 7, then req0 read addr 7 -> rdata0=0x1234.
